dual_rate_sched: RTL and testbench

//  Single-clock replacement for the two-clock f1/f2 datapath. Two period counters generate rate

---
 rtl/dual_rate_sched_pkg.sv | 31 +++
 rtl/dual_rate_sched_if.sv | 33 +++
 rtl/dual_rate_sched_period_counter.sv | 37 +++
 rtl/dual_rate_sched.sv | 113 +++++++++++
 tb/tb_dual_rate_sched.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/dual_rate_sched_pkg.sv
// ---------------------------------------------------------------------------
// dual_rate_sched_pkg
//  Shared definitions for the dual-rate scheduler: channel identifiers,
//  vector bit positions for per-channel signals, default periods and width.
// ---------------------------------------------------------------------------
package dual_rate_sched_pkg;

   // Channel identity, also used as the round-robin priority state.
   typedef enum logic {
      CH1 = 1'b0,
      CH2 = 1'b1
   } chan_e;

   // Bit positions of each channel inside the 2-bit tick/req/grant/pend vectors.
   localparam int CH1_IDX = 0;
   localparam int CH2_IDX = 1;

   // Bit positions inside the sticky overrun vector {ch2,ch1}.
   localparam int OVR_CH1 = 0;
   localparam int OVR_CH2 = 1;

   localparam int P1_DEFAULT = 10;
   localparam int P2_DEFAULT = 8;
   localparam int CW_DEFAULT = 8;

   // The channel that gets priority after the given one wins a contention.
   function automatic chan_e other_chan(input chan_e ch);
      return (ch == CH1) ? CH2 : CH1;
   endfunction

endpackage

// File: rtl/dual_rate_sched_if.sv
// ---------------------------------------------------------------------------
// dual_rate_sched_if
//  Bundles the scheduler's control, operand and result signals.
//   run   : 1 = period counters advance, 0 = counters and pending cleared
//   hold  : 1 = shared evaluation slot unavailable this cycle
//   a,b,c : datapath operands, sampled only on a granted cycle
//   f1,f2 : result registers
//   upd1,upd2 : one-cycle strobes, result written at the preceding edge
//   ovr   : sticky overrun flags {ch2,ch1}
//  master: stimulus side, slave: scheduler side.
// ---------------------------------------------------------------------------
interface dual_rate_sched_if;
   logic       run;
   logic       hold;
   logic       a;
   logic       b;
   logic       c;
   logic       f1;
   logic       f2;
   logic       upd1;
   logic       upd2;
   logic [1:0] ovr;

   modport master (
      output run, hold, a, b, c,
      input  f1, f2, upd1, upd2, ovr
   );

   modport slave (
      input  run, hold, a, b, c,
      output f1, f2, upd1, upd2, ovr
   );
endinterface

// File: rtl/dual_rate_sched_period_counter.sv
// ---------------------------------------------------------------------------
// period_counter
//  Free-running modulo-P counter that produces a rate tick on its last count.
//  Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   run  : 1 = count 0..P-1 and wrap, 0 = count forced to 0 at next edge
//   tick : combinational, high while run=1 and the count equals P-1
// ---------------------------------------------------------------------------
module period_counter #(
   parameter int P  = 10,
   parameter int CW = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   // P may be as large as 2**CW, so P-1 is the largest value that fits in CW bits.
   localparam logic [CW-1:0] LAST = CW'(P - 1);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   assign tick = run & (cnt_reg == LAST);

endmodule

// File: rtl/dual_rate_sched.sv
// ---------------------------------------------------------------------------
// dual_rate_sched
//  Single-clock scheduler for two rate-driven result registers. Two period
//  counters raise ticks; one shared evaluation slot writes one result per
//  cycle, with a round-robin arbiter resolving coincident requests and a
//  one-deep pending flag per channel holding deferred requests.
//  Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active-high (wins over run/hold)
//   bus : dual_rate_sched_if.slave (run, hold, a, b, c in;
//         f1, f2, upd1, upd2, ovr out)
//  Results: f1 <= a & b on a channel-1 grant, f2 <= f1 | c on a channel-2
//  grant (f1 taken before the edge).
// ---------------------------------------------------------------------------
module dual_rate_sched
   import dual_rate_sched_pkg::*;
#(
   parameter int P1 = P1_DEFAULT,
   parameter int P2 = P2_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   dual_rate_sched_if.slave   bus
);

   logic [1:0] tick;
   logic [1:0] req;
   logic [1:0] grant;
   logic       contention;

   logic [1:0] pend_reg;
   logic [1:0] ovr_reg;
   logic [1:0] upd_reg;
   chan_e      prio_reg;
   logic       f1_reg;
   logic       f2_reg;

   // One period counter per channel; bit gi of tick belongs to channel gi.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_counter
         localparam int PERIOD = (gi == CH1_IDX) ? P1 : P2;
         period_counter #(
            .P  (PERIOD),
            .CW (CW)
         ) u_counter (
            .clk  (clk),
            .rst  (rst),
            .run  (bus.run),
            .tick (tick[gi])
         );
      end
   endgenerate

   // A fresh tick requests in the same cycle; a deferred one keeps requesting
   // through its pending flag.
   assign req        = tick | pend_reg;
   assign contention = ~bus.hold & req[CH1_IDX] & req[CH2_IDX];

   always_comb begin
      grant = 2'b00;
      if (!bus.hold) begin
         if (contention) begin
            case (prio_reg)
               CH1:     grant[CH1_IDX] = 1'b1;
               default: grant[CH2_IDX] = 1'b1;
            endcase
         end else begin
            grant = req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_reg <= 2'b00;
         ovr_reg  <= 2'b00;
         upd_reg  <= 2'b00;
         prio_reg <= CH1;
         f1_reg   <= 1'b0;
         f2_reg   <= 1'b0;
      end else begin
         // Dropping run discards pending work, but a grant issued in that
         // same cycle still writes its result below.
         pend_reg <= bus.run ? (req & ~grant) : 2'b00;

         // A tick arriving while the previous one is still pending merges
         // into it; the lost update is only recorded here. ovr survives run=0.
         ovr_reg[OVR_CH1] <= ovr_reg[OVR_CH1] | (tick[CH1_IDX] & pend_reg[CH1_IDX]);
         ovr_reg[OVR_CH2] <= ovr_reg[OVR_CH2] | (tick[CH2_IDX] & pend_reg[CH2_IDX]);

         if (contention) begin
            prio_reg <= other_chan(prio_reg);
         end

         if (grant[CH1_IDX]) begin
            f1_reg <= bus.a & bus.b;
         end
         if (grant[CH2_IDX]) begin
            f2_reg <= f1_reg | bus.c;
         end

         upd_reg <= grant;
      end
   end

   assign bus.f1   = f1_reg;
   assign bus.f2   = f2_reg;
   assign bus.upd1 = upd_reg[CH1_IDX];
   assign bus.upd2 = upd_reg[CH2_IDX];
   assign bus.ovr  = ovr_reg;

endmodule

// File: tb/tb_dual_rate_sched.sv
// ---------------------------------------------------------------------------
// tb_dual_rate_sched
//  Directed bench for dual_rate_sched with P1=10, P2=8. Cycle n is the n-th
//  clock period after reset release; outputs are sampled 1 time unit after
//  the rising edge that opens cycle n. ev[n] holds the expected {upd2,upd1}
//  in cycle n and is checked every cycle.
// ---------------------------------------------------------------------------
module tb_dual_rate_sched;

   logic clk;
   logic rst;

   dual_rate_sched_if bus ();

   dual_rate_sched #(
      .P1 (10),
      .P2 (8),
      .CW (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [1:0] ev [0:127];

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, want);
      end
   endtask

   task automatic clear_ev();
      for (int i = 0; i < 128; i++) ev[i] = 2'b00;
   endtask

   // Uncontended schedule: upd1 every 10 cycles, upd2 every 8, with the two
   // coincidences at 39 and 79 resolved by alternating priority.
   task automatic fill_nominal();
      clear_ev();
      for (int k = 1; k * 10 < 128; k++) ev[k * 10] = ev[k * 10] | 2'b01;
      for (int k = 1; k * 8 < 128; k++)  ev[k * 8]  = ev[k * 8]  | 2'b10;
      ev[40] = 2'b01;
      ev[41] = 2'b10;
      ev[80] = 2'b10;
      ev[81] = 2'b01;
   endtask

   task automatic run_until(input int n);
      while (cyc < n && cyc < 127) begin
         @(posedge clk);
         #1;
         cyc++;
         chk($sformatf("upd@%0d", cyc), {bus.upd2, bus.upd1}, ev[cyc]);
      end
      $display("reached cycle %0d upd=%b f=%b ovr=%b", cyc, {bus.upd2, bus.upd1},
               {bus.f2, bus.f1}, bus.ovr);
   endtask

   // Holds rst for ncyc edges checking the cleared state, then releases it.
   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_f%0d", i), {bus.f2, bus.f1}, 2'b00);
         chk($sformatf("rst_upd%0d", i), {bus.upd2, bus.upd1}, 2'b00);
         chk($sformatf("rst_ovr%0d", i), bus.ovr, 2'b00);
      end
      rst = 1'b0;
      cyc = 0;
      $display("reset released, cycle 0");
   endtask

   initial begin
      rst      = 1'b1;
      bus.run  = 1'b1;
      bus.hold = 1'b0;
      bus.a    = 1'b1;
      bus.b    = 1'b1;
      bus.c    = 1'b1;

      // Test 1: reset with all operands high.
      do_reset(3);

      // Tests 2 and 3: solo ticks and both coincidences.
      bus.c = 1'b0;
      fill_nominal();
      run_until(8);
      chk("t2_f2_first", {1'b0, bus.f2}, 2'b00);
      run_until(10);
      chk("t2_f1_first", {1'b0, bus.f1}, 2'b01);
      run_until(16);
      chk("t2_f2_second", {1'b0, bus.f2}, 2'b01);
      run_until(82);
      chk("t3_ovr", bus.ovr, 2'b00);

      // Test 4: hold over cycles 7..16 forces an overrun on channel 2.
      do_reset(1);
      clear_ev();
      ev[18] = 2'b01;
      ev[19] = 2'b10;
      ev[20] = 2'b01;
      ev[24] = 2'b10;
      run_until(7);
      bus.hold = 1'b1;
      run_until(15);
      chk("t4_ovr_before", bus.ovr, 2'b00);
      run_until(16);
      chk("t4_ovr_set", bus.ovr, 2'b10);
      run_until(17);
      bus.hold = 1'b0;
      run_until(18);
      chk("t4_f1_after", {1'b0, bus.f1}, 2'b01);
      run_until(19);
      chk("t4_f2_after", {1'b0, bus.f2}, 2'b01);
      run_until(24);
      chk("t4_ovr_sticky", bus.ovr, 2'b10);
      // run=0 leaves ovr and the results untouched.
      bus.run = 1'b0;
      run_until(26);
      chk("t4_ovr_run0", bus.ovr, 2'b10);
      chk("t4_f_run0", {bus.f2, bus.f1}, 2'b11);
      bus.run = 1'b1;

      // Test 5: run low for cycles 5..8; counters restart from 0 at cycle 9,
      // so the first ch2 tick is cycle 16 (upd2 17), first ch1 tick 18 (upd1 19).
      do_reset(1);
      chk("t5_ovr_cleared", bus.ovr, 2'b00);
      clear_ev();
      ev[17] = 2'b10;
      ev[19] = 2'b01;
      run_until(5);
      bus.run = 1'b0;
      run_until(9);
      bus.run = 1'b1;
      run_until(17);
      chk("t5_f2", {1'b0, bus.f2}, 2'b00);
      run_until(19);
      chk("t5_f1", {1'b0, bus.f1}, 2'b01);

      // Test 6: reset asserted in the coincidence cycle 39 suppresses both updates.
      do_reset(1);
      fill_nominal();
      run_until(39);
      chk("t6_f_pre", {bus.f2, bus.f1}, 2'b11);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_upd_40", {bus.upd2, bus.upd1}, 2'b00);
      chk("t6_f_40", {bus.f2, bus.f1}, 2'b00);
      chk("t6_ovr_40", bus.ovr, 2'b00);
      rst = 1'b0;
      cyc = 0;
      clear_ev();
      ev[8]  = 2'b10;
      ev[10] = 2'b01;
      ev[16] = 2'b10;
      run_until(8);
      chk("t6_f2_first", {1'b0, bus.f2}, 2'b00);
      run_until(10);
      chk("t6_f1_first", {1'b0, bus.f1}, 2'b01);
      run_until(16);
      chk("t6_f2_second", {1'b0, bus.f2}, 2'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
